axi_lite_regbank: RTL and testbench
===================================

# axi_lite_regbank

Parametrised AXI4-Lite slave register bank, the next-generation control/status port for the TRNG IP and its successors. It exposes NUM_REGS 32-bit write registers and NUM_REGS 32-bit read ports behind one AXI-Lite slave. Unlike the fixed four-register controller, it accepts AW and W independently, supports self-clearing pulse bits and read side-effect strobes, and returns SLVERR on unmapped addresses. It sits between the PS interconnect and the TRNG core datapath.

## Interface

- ADDR_W, 6, AXI address width; register index = ADDR[ADDR_W-1:2]
- NUM_REGS, 8, mapped registers; NUM_REGS <= 2^(ADDR_W-2), or 2^(ADDR_W-2)-2 with IRQ
- RESET_VAL, '0, NUM_REGS*32 flat reset values of the write registers
- PULSE_MASK, '0, NUM_REGS*32 flat; set bits self-clear one cycle after being written
- AXI_CTRL_ACLK  in  1  sole clock
- AXI_CTRL_ARESET  in  1  reset, synchronous, active-high
- AXI_CTRL_AW{ADDR,PROT,VALID,READY}, W{DATA,STRB,VALID,READY}, B{RESP,VALID,READY}, AR{ADDR,PROT,VALID,READY}, R{DATA,RESP,VALID,READY}  AXI4-Lite, ADDR_W-bit addresses, 32-bit data; PROT ignored
- REG_WDATA  out  NUM_REGS*32  write-register contents
- REG_WPULSE  out  NUM_REGS  one-cycle strobe per register write (any WSTRB)
- REG_RDATA  in  NUM_REGS*32  read-port values
- REG_RPULSE  out  NUM_REGS  one-cycle strobe per accepted read (e.g. FIFO pop)
- IRQ_EVENT  in  32  interrupt event pulses
- IRQ  out  1  level interrupt

## Operation

- Write: one-entry AW holder and one-entry W holder. AWREADY = AW holder empty; WREADY = W holder empty. Either may arrive first.
- When both holders are full and BVALID is low: commit. For an in-range index, update byte lanes where WSTRB is set, pulse REG_WPULSE[idx], and set BRESP=00. For an out-of-range index, write nothing and set BRESP=10. In both cases raise BVALID.
- Holders are freed on the B handshake. No new AW or W is accepted until then.
- Pulse bits: a written PULSE_MASK bit holds its written value for exactly one cycle, then returns to 0. Writing 0 has no visible effect.
- Read: ARREADY = !RVALID. On the AR handshake, capture REG_RDATA[idx] into RDATA, set RRESP=00, and pulse REG_RPULSE[idx]. For an out-of-range index, RDATA=0, RRESP=10, and there is no pulse. RVALID drops on the R handshake.
- Read and write channels are fully independent. A read and a write to the same index committing on the same edge: the read returns REG_RDATA sampled at that edge; write-register contents are not looped back.
- Reset: all READY, VALID, RESP, RDATA, pulse outputs and IRQ are 0. REG_WDATA = RESET_VAL. Holders are empty. Reset mid-transaction discards it with no B/R response.

## Timing

- Write latency: the edge that fills the second holder is followed, one edge later, by REG_WDATA updated, REG_WPULSE high, and BVALID high, all in the same cycle.
- AW+W same cycle with BREADY held high: BVALID is high 1 cycle; the next AW is accepted in the cycle after the B handshake, giving a throughput of 1 write per 3 cycles.
- Read latency: AR handshake at edge e. RVALID, RDATA and REG_RPULSE are high in the cycle after e. With RREADY high, the next AR is accepted the cycle after that, giving 1 read per 2 cycles.
- Outputs hold stable while VALID is high and READY is low.

## Configuration

- AXI_LITE_REGBANK_IRQ_EN defined: index NUM_REGS is PEND (read; write-1-to-clear) and index NUM_REGS+1 is ENABLE (read/write, reset 0).
  - A set IRQ_EVENT bit sets PEND the same edge; a simultaneous event and clear leaves the bit set.
  - IRQ = |(PEND & ENABLE), registered, one cycle after PEND/ENABLE change.
- Not defined: those indices are out of range (SLVERR), IRQ_EVENT is ignored, and IRQ is tied to 0.

## Structure

- Package axi_lite_regbank_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, IRQ register offsets (PEND_OFS=0, EN_OFS=1 relative to NUM_REGS), function for the index-in-range check.
- Sub-module axi_lite_hold_reg: one-entry valid/ready holding register, instantiated for AW (ADDR_W bits) and W (36 bits).

## Test plan

- AW+W same cycle to 0x04, WDATA=0x12345678, WSTRB=F → BVALID 2 cycles after, BRESP=00, REG_WDATA[1]=0x12345678, REG_WPULSE=0x02 for 1 cycle.
- W 3 cycles before AW, WSTRB=0x4, data 0xAABBCCDD, reg 2 reset 0 → REG_WDATA[2]=0x00BB0000, WREADY low until after B handshake.
- PULSE_MASK[0]=1, write 0x1 to 0x00 → REG_WDATA[0] bit0 high exactly 1 cycle.
- Read 0x3C with NUM_REGS=8 → RRESP=10, RDATA=0, REG_RPULSE=0; write 0x3C → BRESP=10, no REG_WDATA change.
- RREADY held low 5 cycles after read of reg 3 (REG_RDATA changing) → RDATA constant, ARREADY low, one REG_RPULSE.
- With IRQ_EN: ENABLE=0x1, IRQ_EVENT[0] pulse → IRQ=1; write PEND=0x1 while IRQ_EVENT[0]=1 → stays 1; clear again without event → IRQ=0.

Source files
------------

// File: rtl/axi_lite_regbank_pkg.sv
// rtl/axi_lite_regbank_pkg.sv - shared response codes, IRQ register offsets and lane helpers for axi_lite_regbank
package axi_lite_regbank_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    localparam int PEND_OFS = 0;
    localparam int EN_OFS   = 1;

    function automatic logic idx_in_range(input int idx, input int limit);
        return (idx >= 0) && (idx < limit);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        return (old_val & ~byte_mask(strb)) | (new_val & byte_mask(strb));
    endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// rtl/axi_lite_hold_reg.sv - one-entry valid/ready holding register, emptied only by an explicit m_tready
module axi_lite_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic         full;
    logic [W-1:0] data_q;

    // Held off during reset so every READY reads 0 while reset is asserted.
    assign s_tready = !full && !rst;
    assign m_tvalid = full;
    assign m_tdata  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (s_tvalid && s_tready) begin
            full   <= 1'b1;
            data_q <= s_tdata;
        end else if (m_tready) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// rtl/axi_lite_regbank.sv - AXI4-Lite register bank; define AXI_LITE_REGBANK_IRQ_EN for the PEND/ENABLE interrupt pair
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int                     ADDR_W     = 6,
    parameter int                     NUM_REGS   = 8,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL  = '0,
    parameter logic [NUM_REGS*32-1:0] PULSE_MASK = '0
) (
    input  logic                     AXI_CTRL_ACLK,
    input  logic                     AXI_CTRL_ARESET,
    input  logic [ADDR_W-1:0]        AXI_CTRL_AWADDR,
    input  logic [2:0]               AXI_CTRL_AWPROT,
    input  logic                     AXI_CTRL_AWVALID,
    output logic                     AXI_CTRL_AWREADY,
    input  logic [31:0]              AXI_CTRL_WDATA,
    input  logic [3:0]               AXI_CTRL_WSTRB,
    input  logic                     AXI_CTRL_WVALID,
    output logic                     AXI_CTRL_WREADY,
    output logic [1:0]               AXI_CTRL_BRESP,
    output logic                     AXI_CTRL_BVALID,
    input  logic                     AXI_CTRL_BREADY,
    input  logic [ADDR_W-1:0]        AXI_CTRL_ARADDR,
    input  logic [2:0]               AXI_CTRL_ARPROT,
    input  logic                     AXI_CTRL_ARVALID,
    output logic                     AXI_CTRL_ARREADY,
    output logic [31:0]              AXI_CTRL_RDATA,
    output logic [1:0]               AXI_CTRL_RRESP,
    output logic                     AXI_CTRL_RVALID,
    input  logic                     AXI_CTRL_RREADY,
    output logic [NUM_REGS*32-1:0]   REG_WDATA,
    output logic [NUM_REGS-1:0]      REG_WPULSE,
    input  logic [NUM_REGS*32-1:0]   REG_RDATA,
    output logic [NUM_REGS-1:0]      REG_RPULSE,
    input  logic [31:0]              IRQ_EVENT,
    output logic                     IRQ
);

    localparam int IDX_W = ADDR_W - 2;
`ifdef AXI_LITE_REGBANK_IRQ_EN
    localparam int NUM_ADDR = NUM_REGS + 2;
`else
    localparam int NUM_ADDR = NUM_REGS;
`endif

    logic [ADDR_W-1:0]   aw_q;
    logic                aw_full;
    logic [35:0]         w_q;
    logic                w_full;
    logic                bvalid;
    logic [1:0]          bresp;
    logic                b_hs;
    logic                commit;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_hit;
    logic [31:0]         wr_data;
    logic [3:0]          wr_strb;

    logic [31:0]         wreg   [NUM_REGS];
    logic [31:0]         rd_arr [NUM_REGS];
    logic [NUM_REGS-1:0] wpulse;
    logic [NUM_REGS-1:0] rpulse;
    logic                rvalid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                arready;
    logic                ar_hs;
    logic [IDX_W-1:0]    ar_idx;
    logic                rd_hit;
    logic [31:0]         rd_val;
    logic [31:0]         pend;
    logic [31:0]         enable;

    // Both holders free only on the B handshake, so a new AW/W waits for the response.
    assign b_hs = bvalid && AXI_CTRL_BREADY;

    axi_lite_hold_reg #(.W(ADDR_W)) u_aw_hold (
        .clk      (AXI_CTRL_ACLK),
        .rst      (AXI_CTRL_ARESET),
        .s_tdata  (AXI_CTRL_AWADDR),
        .s_tvalid (AXI_CTRL_AWVALID),
        .s_tready (AXI_CTRL_AWREADY),
        .m_tdata  (aw_q),
        .m_tvalid (aw_full),
        .m_tready (b_hs)
    );

    axi_lite_hold_reg #(.W(36)) u_w_hold (
        .clk      (AXI_CTRL_ACLK),
        .rst      (AXI_CTRL_ARESET),
        .s_tdata  ({AXI_CTRL_WSTRB, AXI_CTRL_WDATA}),
        .s_tvalid (AXI_CTRL_WVALID),
        .s_tready (AXI_CTRL_WREADY),
        .m_tdata  (w_q),
        .m_tvalid (w_full),
        .m_tready (b_hs)
    );

    assign wr_idx  = aw_q[ADDR_W-1:2];
    assign wr_data = w_q[31:0];
    assign wr_strb = w_q[35:32];
    assign wr_hit  = idx_in_range(int'(wr_idx), NUM_ADDR);
    assign commit  = aw_full && w_full && !bvalid;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign REG_WDATA[g*32 +: 32] = wreg[g];
        assign rd_arr[g]             = REG_RDATA[g*32 +: 32];
    end

    // Pulse-mask bits are cleared every cycle; a commit re-applies them for one cycle only.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (AXI_CTRL_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wreg[i] <= RESET_VAL[i*32 +: 32];
            end
            wpulse <= '0;
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else begin
            wpulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && wr_idx == IDX_W'(i)) begin
                    wreg[i]   <= lane_merge(wreg[i] & ~PULSE_MASK[i*32 +: 32], wr_data, wr_strb);
                    wpulse[i] <= 1'b1;
                end else begin
                    wreg[i]   <= wreg[i] & ~PULSE_MASK[i*32 +: 32];
                end
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid <= 1'b0;
            end
        end
    end

    assign AXI_CTRL_BVALID = bvalid;
    assign AXI_CTRL_BRESP  = bresp;
    assign REG_WPULSE      = wpulse;

    assign arready = !rvalid && !AXI_CTRL_ARESET;
    assign ar_hs   = AXI_CTRL_ARVALID && arready;
    assign ar_idx  = AXI_CTRL_ARADDR[ADDR_W-1:2];
    assign rd_hit  = idx_in_range(int'(ar_idx), NUM_ADDR);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_val = rd_arr[i];
            end
        end
`ifdef AXI_LITE_REGBANK_IRQ_EN
        if (int'(ar_idx) == NUM_REGS + PEND_OFS) begin
            rd_val = pend;
        end
        if (int'(ar_idx) == NUM_REGS + EN_OFS) begin
            rd_val = enable;
        end
`endif
    end

    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (AXI_CTRL_ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            rpulse <= '0;
        end else begin
            rpulse <= '0;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ar_idx == IDX_W'(i)) begin
                        rpulse[i] <= 1'b1;
                    end
                end
            end else if (rvalid && AXI_CTRL_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign AXI_CTRL_ARREADY = arready;
    assign AXI_CTRL_RVALID  = rvalid;
    assign AXI_CTRL_RDATA   = rdata;
    assign AXI_CTRL_RRESP   = rresp;
    assign REG_RPULSE       = rpulse;

`ifdef AXI_LITE_REGBANK_IRQ_EN
    logic [31:0] pend_clr;
    logic        irq_q;

    assign pend_clr = (commit && int'(wr_idx) == NUM_REGS + PEND_OFS)
                    ? (wr_data & byte_mask(wr_strb)) : '0;

    // New events are ORed in after the clear, so a same-edge event wins.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (AXI_CTRL_ARESET) begin
            pend   <= '0;
            enable <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend  <= (pend & ~pend_clr) | IRQ_EVENT;
            irq_q <= |(pend & enable);
            if (commit && int'(wr_idx) == NUM_REGS + EN_OFS) begin
                enable <= lane_merge(enable, wr_data, wr_strb);
            end
        end
    end

    assign IRQ = irq_q;
`else
    logic unused_irq;

    assign pend       = '0;
    assign enable     = '0;
    assign IRQ        = 1'b0;
    assign unused_irq = ^{IRQ_EVENT, pend, enable};
`endif

    logic unused_ok;
    assign unused_ok = ^{AXI_CTRL_AWPROT, AXI_CTRL_ARPROT, AXI_CTRL_ARADDR[1:0], aw_q[1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb/tb_axi_lite_regbank.sv - randomized self-checking bench for axi_lite_regbank against a register-map model
module tb_axi_lite_regbank;

    localparam logic [255:0] RV = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                   32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_0001, 32'h0000_0000};
    localparam logic [255:0] PM = {32'h0, 32'h0, 32'h0000_F000, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0000_0001};

    logic         AXI_CTRL_ACLK = 1'b0;
    logic         AXI_CTRL_ARESET;
    logic [5:0]   AXI_CTRL_AWADDR;
    logic [2:0]   AXI_CTRL_AWPROT;
    logic         AXI_CTRL_AWVALID;
    logic         AXI_CTRL_AWREADY;
    logic [31:0]  AXI_CTRL_WDATA;
    logic [3:0]   AXI_CTRL_WSTRB;
    logic         AXI_CTRL_WVALID;
    logic         AXI_CTRL_WREADY;
    logic [1:0]   AXI_CTRL_BRESP;
    logic         AXI_CTRL_BVALID;
    logic         AXI_CTRL_BREADY;
    logic [5:0]   AXI_CTRL_ARADDR;
    logic [2:0]   AXI_CTRL_ARPROT;
    logic         AXI_CTRL_ARVALID;
    logic         AXI_CTRL_ARREADY;
    logic [31:0]  AXI_CTRL_RDATA;
    logic [1:0]   AXI_CTRL_RRESP;
    logic         AXI_CTRL_RVALID;
    logic         AXI_CTRL_RREADY;
    logic [255:0] REG_WDATA;
    logic [7:0]   REG_WPULSE;
    logic [255:0] REG_RDATA;
    logic [7:0]   REG_RPULSE;
    logic [31:0]  IRQ_EVENT;
    logic         IRQ;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]  m_wreg [8];
    logic [31:0]  m_pend;
    logic [31:0]  m_en;
    logic [255:0] pm_v = PM;
    logic [255:0] rv_v = RV;

    axi_lite_regbank #(
        .ADDR_W     (6),
        .NUM_REGS   (8),
        .RESET_VAL  (RV),
        .PULSE_MASK (PM)
    ) dut (
        .AXI_CTRL_ACLK    (AXI_CTRL_ACLK),
        .AXI_CTRL_ARESET  (AXI_CTRL_ARESET),
        .AXI_CTRL_AWADDR  (AXI_CTRL_AWADDR),
        .AXI_CTRL_AWPROT  (AXI_CTRL_AWPROT),
        .AXI_CTRL_AWVALID (AXI_CTRL_AWVALID),
        .AXI_CTRL_AWREADY (AXI_CTRL_AWREADY),
        .AXI_CTRL_WDATA   (AXI_CTRL_WDATA),
        .AXI_CTRL_WSTRB   (AXI_CTRL_WSTRB),
        .AXI_CTRL_WVALID  (AXI_CTRL_WVALID),
        .AXI_CTRL_WREADY  (AXI_CTRL_WREADY),
        .AXI_CTRL_BRESP   (AXI_CTRL_BRESP),
        .AXI_CTRL_BVALID  (AXI_CTRL_BVALID),
        .AXI_CTRL_BREADY  (AXI_CTRL_BREADY),
        .AXI_CTRL_ARADDR  (AXI_CTRL_ARADDR),
        .AXI_CTRL_ARPROT  (AXI_CTRL_ARPROT),
        .AXI_CTRL_ARVALID (AXI_CTRL_ARVALID),
        .AXI_CTRL_ARREADY (AXI_CTRL_ARREADY),
        .AXI_CTRL_RDATA   (AXI_CTRL_RDATA),
        .AXI_CTRL_RRESP   (AXI_CTRL_RRESP),
        .AXI_CTRL_RVALID  (AXI_CTRL_RVALID),
        .AXI_CTRL_RREADY  (AXI_CTRL_RREADY),
        .REG_WDATA        (REG_WDATA),
        .REG_WPULSE       (REG_WPULSE),
        .REG_RDATA        (REG_RDATA),
        .REG_RPULSE       (REG_RPULSE),
        .IRQ_EVENT        (IRQ_EVENT),
        .IRQ              (IRQ)
    );

    always #5 AXI_CTRL_ACLK = ~AXI_CTRL_ACLK;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input int idx);
`ifdef AXI_LITE_REGBANK_IRQ_EN
        return idx < 10;
`else
        return idx < 8;
`endif
    endfunction

    function automatic logic [31:0] strb_bits(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_wreg[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge AXI_CTRL_ACLK);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold);
        bit           aw_done = 0;
        bit           w_done  = 0;
        bit           ah, wh;
        int           c   = 0;
        int           idx = int'(addr[5:2]);
        logic [31:0]  bm  = strb_bits(strb);
        logic [31:0]  nv;
        logic [255:0] exp_flat;
        logic [7:0]   exp_pulse = 8'h00;
        while (!(aw_done && w_done) && c < 20) begin
            AXI_CTRL_AWADDR  = addr;
            AXI_CTRL_AWVALID = !aw_done && (c >= aw_dly);
            AXI_CTRL_WDATA   = data;
            AXI_CTRL_WSTRB   = strb;
            AXI_CTRL_WVALID  = !w_done && (c >= w_dly);
            if (aw_done) check_eq("awready_held", AXI_CTRL_AWREADY, 0);
            if (w_done)  check_eq("wready_held", AXI_CTRL_WREADY, 0);
            ah = AXI_CTRL_AWVALID && AXI_CTRL_AWREADY;
            wh = AXI_CTRL_WVALID && AXI_CTRL_WREADY;
            tick();
            if (ah) aw_done = 1;
            if (wh) w_done = 1;
            c++;
        end
        AXI_CTRL_AWVALID = 0;
        AXI_CTRL_WVALID  = 0;
        check_eq("aw_w_accepted", aw_done && w_done, 1);
        check_eq("bvalid_early", AXI_CTRL_BVALID, 0);

        exp_flat = model_flat();
        if (idx < 8) begin
            nv = (m_wreg[idx] & ~bm) | (data & bm);
            exp_flat[idx*32 +: 32] = nv;
            exp_pulse = 8'(1) << idx;
            m_wreg[idx] = nv & ~pm_v[idx*32 +: 32];
        end
`ifdef AXI_LITE_REGBANK_IRQ_EN
        if (idx == 8) m_pend = m_pend & ~(data & bm);
        if (idx == 9) m_en = (m_en & ~bm) | (data & bm);
`endif
        tick();
        check_eq("bvalid", AXI_CTRL_BVALID, 1);
        check_eq("bresp", AXI_CTRL_BRESP, addr_ok(idx) ? 2'b00 : 2'b10);
        check_eq("wpulse", REG_WPULSE, exp_pulse);
        check_eq("wdata_commit", REG_WDATA, exp_flat);

        AXI_CTRL_BREADY = (b_hold == 0);
        for (int h = 0; h < b_hold; h++) begin
            tick();
            check_eq("bvalid_hold", AXI_CTRL_BVALID, 1);
            check_eq("wpulse_once", REG_WPULSE, 0);
            check_eq("wdata_after", REG_WDATA, model_flat());
            check_eq("awready_b", AXI_CTRL_AWREADY, 0);
            n_vec++;
            if (AXI_CTRL_BVALID !== 1'b1 || REG_WDATA !== model_flat()) begin
                n_err++;
                $display("FAIL b_hold_inline: bvalid %0b wdata %0h", AXI_CTRL_BVALID, REG_WDATA);
            end
            if (h == b_hold - 1) AXI_CTRL_BREADY = 1;
        end
        tick();
        AXI_CTRL_BREADY = 0;
        check_eq("bvalid_drop", AXI_CTRL_BVALID, 0);
        check_eq("awready_free", AXI_CTRL_AWREADY, 1);
        check_eq("wready_free", AXI_CTRL_WREADY, 1);
        check_eq("wdata_settled", REG_WDATA, model_flat());
    endtask

    task automatic do_read(input logic [5:0] addr, input int r_hold);
        int          idx = int'(addr[5:2]);
        logic [31:0] erd = 32'h0;
        logic [7:0]  ep  = 8'h00;
        if (idx < 8) begin
            erd = REG_RDATA[idx*32 +: 32];
            ep  = 8'(1) << idx;
        end
`ifdef AXI_LITE_REGBANK_IRQ_EN
        if (idx == 8) erd = m_pend;
        if (idx == 9) erd = m_en;
`endif
        AXI_CTRL_ARADDR  = addr;
        AXI_CTRL_ARVALID = 1;
        check_eq("arready_idle", AXI_CTRL_ARREADY, 1);
        tick();
        AXI_CTRL_ARVALID = 0;
        check_eq("rvalid", AXI_CTRL_RVALID, 1);
        check_eq("rdata", AXI_CTRL_RDATA, erd);
        check_eq("rresp", AXI_CTRL_RRESP, addr_ok(idx) ? 2'b00 : 2'b10);
        check_eq("rpulse", REG_RPULSE, ep);
        AXI_CTRL_RREADY = (r_hold == 0);
        for (int h = 0; h < r_hold; h++) begin
            for (int i = 0; i < 8; i++) REG_RDATA[i*32 +: 32] = $urandom;
            tick();
            check_eq("rvalid_hold", AXI_CTRL_RVALID, 1);
            check_eq("rdata_stable", AXI_CTRL_RDATA, erd);
            check_eq("arready_busy", AXI_CTRL_ARREADY, 0);
            check_eq("rpulse_once", REG_RPULSE, 0);
            n_vec++;
            if (AXI_CTRL_RDATA !== erd) begin
                n_err++;
                $display("FAIL r_hold_inline: rdata %0h expected %0h", AXI_CTRL_RDATA, erd);
            end
            n_vec++;
            if (AXI_CTRL_ARREADY !== 1'b0) begin
                n_err++;
                $display("FAIL r_hold_arready: %0b", AXI_CTRL_ARREADY);
            end
            if (h == r_hold - 1) AXI_CTRL_RREADY = 1;
        end
        tick();
        AXI_CTRL_RREADY = 0;
        check_eq("rvalid_drop", AXI_CTRL_RVALID, 0);
        check_eq("arready_back", AXI_CTRL_ARREADY, 1);
    endtask

    initial begin
        AXI_CTRL_ARESET  = 1;
        AXI_CTRL_AWADDR  = '0;
        AXI_CTRL_AWPROT  = '0;
        AXI_CTRL_AWVALID = 0;
        AXI_CTRL_WDATA   = '0;
        AXI_CTRL_WSTRB   = '0;
        AXI_CTRL_WVALID  = 0;
        AXI_CTRL_BREADY  = 0;
        AXI_CTRL_ARADDR  = '0;
        AXI_CTRL_ARPROT  = '0;
        AXI_CTRL_ARVALID = 0;
        AXI_CTRL_RREADY  = 0;
        IRQ_EVENT        = '0;
        for (int i = 0; i < 8; i++) REG_RDATA[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) m_wreg[i] = rv_v[i*32 +: 32];
        m_pend = '0;
        m_en   = '0;

        repeat (3) tick();
        check_eq("rst_awready", AXI_CTRL_AWREADY, 0);
        check_eq("rst_wready", AXI_CTRL_WREADY, 0);
        check_eq("rst_arready", AXI_CTRL_ARREADY, 0);
        check_eq("rst_bvalid", AXI_CTRL_BVALID, 0);
        check_eq("rst_rvalid", AXI_CTRL_RVALID, 0);
        check_eq("rst_rdata", AXI_CTRL_RDATA, 0);
        check_eq("rst_wdata", REG_WDATA, RV);
        check_eq("rst_pulses", {REG_WPULSE, REG_RPULSE}, 0);
        check_eq("rst_irq", IRQ, 0);
        AXI_CTRL_ARESET = 0;
        tick();

        do_write(6'h04, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_write(6'h08, 32'hAABB_CCDD, 4'h4, 3, 0, 0);
        check_eq("byte_lane_reg2", REG_WDATA[95:64], 32'h00BB_0000);
        do_write(6'h00, 32'h0000_0001, 4'hF, 0, 0, 2);
        do_write(6'h14, 32'h1234_ABCD, 4'h3, 1, 2, 1);
        do_read(6'h3C, 0);
        do_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(6'h0C, 5);

        AXI_CTRL_AWADDR  = 6'h10;
        AXI_CTRL_AWVALID = 1;
        AXI_CTRL_WDATA   = 32'h0BAD_F00D;
        AXI_CTRL_WSTRB   = 4'hF;
        AXI_CTRL_WVALID  = 1;
        tick();
        AXI_CTRL_AWVALID = 0;
        AXI_CTRL_WVALID  = 0;
        AXI_CTRL_ARESET  = 1;
        tick();
        AXI_CTRL_ARESET  = 0;
        for (int i = 0; i < 8; i++) m_wreg[i] = rv_v[i*32 +: 32];
        tick();
        check_eq("rst_mid_bvalid", AXI_CTRL_BVALID, 0);
        check_eq("rst_mid_awready", AXI_CTRL_AWREADY, 1);
        check_eq("rst_mid_wdata", REG_WDATA, model_flat());
        n_vec++;
        if (AXI_CTRL_BVALID !== 1'b0 || REG_WDATA !== model_flat()) begin
            n_err++;
            $display("FAIL rst_mid_inline: bvalid %0b wdata %0h", AXI_CTRL_BVALID, REG_WDATA);
        end

`ifdef AXI_LITE_REGBANK_IRQ_EN
        do_write(6'h24, 32'h0000_0001, 4'hF, 0, 0, 0);
        IRQ_EVENT = 32'h1;
        tick();
        IRQ_EVENT = 32'h0;
        m_pend = 32'h1;
        check_eq("irq_lag", IRQ, 0);
        tick();
        check_eq("irq_set", IRQ, 1);
        IRQ_EVENT = 32'h1;
        do_write(6'h20, 32'h0000_0001, 4'hF, 0, 0, 0);
        IRQ_EVENT = 32'h0;
        m_pend = 32'h1;
        tick();
        check_eq("irq_event_wins", IRQ, 1);
        do_read(6'h20, 0);
        do_write(6'h20, 32'h0000_0001, 4'hF, 0, 0, 0);
        check_eq("irq_cleared", IRQ, 0);
        do_read(6'h24, 1);
`else
        IRQ_EVENT = 32'hFFFF_FFFF;
        repeat (2) tick();
        IRQ_EVENT = 32'h0;
        check_eq("irq_tied", IRQ, 0);
        do_read(6'h20, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                for (int i = 0; i < 8; i++) REG_RDATA[i*32 +: 32] = $urandom;
                do_read(a, $urandom_range(0, 3));
            end
            n_vec++;
            if (REG_WDATA !== model_flat()) begin
                n_err++;
                $display("FAIL rand_wdata_inline: got %0h expected %0h", REG_WDATA, model_flat());
            end
        end
        check_eq("irq_final", IRQ, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
